foc_sample_sequencer: RTL and testbench

- Front end and initiator for the FOC control core.
- On each PWM-synchronous trigger it sequences four ADC conversions: phase A, B and C currents, then resolver angle.
- It subtracts per-phase calibration offsets with saturation and latches the ECU current target and PWM period.
- It presents one coherent sample set to the FOC core on a valid/ready handshake, and counts triggers lost while a cycle is in flight.

---
 rtl/foc_sample_sequencer.sv | 148 ++++++++++++++
 tb/tb_foc_sample_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/foc_sample_sequencer.sv
// ADC conversion sequencer feeding the FOC core: per PWM trigger it converts phase A/B/C
// currents and resolver angle, removes phase offsets and hands one coherent set over valid/ready.
//
// state      | meaning
// ST_IDLE    | waiting for an enabled trigger
// ST_REQ     | one-cycle adc_req for channel ch
// ST_WAIT    | waiting for adc_valid, timeout timer running
// ST_PRESENT | sample set offered to the FOC core until ready_in
module foc_sample_sequencer #(
    parameter int D_WIDTH     = 16,
    parameter int ADC_TIMEOUT = 255,
    parameter int OVR_W       = 8
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               enable,
    input  logic               trig,
    input  logic               clr_err,
    output logic               adc_req,
    output logic [1:0]         adc_ch,
    input  logic               adc_valid,
    input  logic [D_WIDTH-1:0] adc_data,
    input  logic [D_WIDTH-1:0] offA,
    input  logic [D_WIDTH-1:0] offB,
    input  logic [D_WIDTH-1:0] offC,
    input  logic [D_WIDTH-1:0] currT_in,
    input  logic [D_WIDTH-1:0] periodTop_in,
    output logic [D_WIDTH-1:0] angle_out,
    output logic [D_WIDTH-1:0] currA_out,
    output logic [D_WIDTH-1:0] currB_out,
    output logic [D_WIDTH-1:0] currC_out,
    output logic [D_WIDTH-1:0] currT_out,
    output logic [D_WIDTH-1:0] periodTop_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               busy,
    output logic               adc_err,
    output logic [OVR_W-1:0]   ovr_cnt
);

    localparam int TW = $clog2(ADC_TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_PRESENT} state_t;

    state_t             state, state_nxt;
    logic [1:0]         ch;
    logic [TW-1:0]      tmr;
    logic [D_WIDTH-1:0] currT_hold, period_hold;
    logic               accept, capture, timeout;

    function automatic logic [D_WIDTH-1:0] sat_sub(input logic [D_WIDTH-1:0] a,
                                                   input logic [D_WIDTH-1:0] b);
        logic [D_WIDTH:0] d;
        d = {a[D_WIDTH-1], a} - {b[D_WIDTH-1], b};
        if (d[D_WIDTH] != d[D_WIDTH-1])
            sat_sub = d[D_WIDTH] ? {1'b1, {(D_WIDTH-1){1'b0}}} : {1'b0, {(D_WIDTH-1){1'b1}}};
        else
            sat_sub = d[D_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        adc_req   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig && enable) begin
                    accept    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                adc_req   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (adc_valid) begin
                    capture   = 1'b1;
                    state_nxt = (ch == 2'd3) ? ST_PRESENT : ST_REQ;
                end else if (tmr == '0) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (ready_in) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign valid_out = (state == ST_PRESENT);
    assign busy      = (state != ST_IDLE);
    assign adc_ch    = ch;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ch            <= 2'd0;
            tmr           <= '0;
            currT_hold    <= '0;
            period_hold   <= '0;
            angle_out     <= '0;
            currA_out     <= '0;
            currB_out     <= '0;
            currC_out     <= '0;
            currT_out     <= '0;
            periodTop_out <= '0;
            adc_err       <= 1'b0;
            ovr_cnt       <= '0;
        end else begin
            if (accept) begin
                ch          <= 2'd0;
                currT_hold  <= currT_in;
                period_hold <= periodTop_in;
            end
            // Timer reloads on every request; terminal count 0 marks ADC_TIMEOUT silent WAIT cycles.
            if (state == ST_REQ)
                tmr <= TW'(ADC_TIMEOUT - 1);
            else if (state == ST_WAIT && !adc_valid && tmr != '0)
                tmr <= tmr - TW'(1);
            if (capture) begin
                case (ch)
                    2'd0: currA_out <= sat_sub(adc_data, offA);
                    2'd1: currB_out <= sat_sub(adc_data, offB);
                    2'd2: currC_out <= sat_sub(adc_data, offC);
                    2'd3: begin
                        angle_out     <= adc_data;
                        currT_out     <= currT_hold;
                        periodTop_out <= period_hold;
                    end
                endcase
                if (ch != 2'd3) ch <= ch + 2'd1;
            end
            if (timeout)      adc_err <= 1'b1;
            else if (clr_err) adc_err <= 1'b0;
            if (trig && state != ST_IDLE && !(&ovr_cnt))
                ovr_cnt <= ovr_cnt + OVR_W'(1);
        end
    end

endmodule

// File: tb/tb_foc_sample_sequencer.sv
// Self-checking bench for foc_sample_sequencer: ADC responder with programmable latency and a
// reference model built from saturating integer arithmetic and latency sums.
module tb_foc_sample_sequencer;
    localparam int DW = 16;
    localparam int TO = 255;
    localparam int OW = 8;

    logic          clk = 1'b0, rstb = 1'b0, enable = 1'b0, trig = 1'b0, clr_err = 1'b0;
    logic          adc_valid = 1'b0, ready_in = 1'b0;
    logic [DW-1:0] adc_data = '0, offA = '0, offB = '0, offC = '0, currT_in = '0, periodTop_in = '0;
    logic          adc_req, valid_out, busy, adc_err;
    logic [1:0]    adc_ch;
    logic [DW-1:0] angle_out, currA_out, currB_out, currC_out, currT_out, periodTop_out;
    logic [OW-1:0] ovr_cnt;

    foc_sample_sequencer #(.D_WIDTH(DW), .ADC_TIMEOUT(TO), .OVR_W(OW)) dut (
        .clk(clk), .rstb(rstb), .enable(enable), .trig(trig), .clr_err(clr_err),
        .adc_req(adc_req), .adc_ch(adc_ch), .adc_valid(adc_valid), .adc_data(adc_data),
        .offA(offA), .offB(offB), .offC(offC), .currT_in(currT_in), .periodTop_in(periodTop_in),
        .angle_out(angle_out), .currA_out(currA_out), .currB_out(currB_out), .currC_out(currC_out),
        .currT_out(currT_out), .periodTop_out(periodTop_out), .valid_out(valid_out),
        .ready_in(ready_in), .busy(busy), .adc_err(adc_err), .ovr_cnt(ovr_cnt)
    );

    always #5 clk = ~clk;

    int            n_tests = 0, n_fail = 0;
    int            req_cnt = 0, ovr_exp = 0, mute_ch = -1;
    logic [DW-1:0] adc_vals[4];
    int            adc_lat[4];
    logic [DW-1:0] e_a, e_b, e_c, e_ang, e_t, e_p;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sat(input logic [DW-1:0] x, input logic [DW-1:0] o);
        int v;
        v = int'($signed(x)) - int'($signed(o));
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return DW'(v);
    endfunction

    function automatic int ovr_model();
        return (ovr_exp > 255) ? 255 : ovr_exp;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ADC model: answers a request adc_lat[ch] cycles later unless the channel is muted.
    initial begin
        int pend = 0;
        logic [DW-1:0] pd = '0;
        forever begin
            @(posedge clk);
            #1;
            adc_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    adc_valid = 1'b1;
                    adc_data  = pd;
                end
            end
            if (adc_req === 1'b1 && int'(adc_ch) != mute_ch) begin
                pend = adc_lat[adc_ch];
                pd   = adc_vals[adc_ch];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (adc_req === 1'b1) req_cnt++;
    end

    task automatic wait_valid(input bit rnd_trig, output int k, output bit got);
        k = 0;
        got = 1'b0;
        while (k < 300) begin
            step();
            k++;
            trig = 1'b0;
            if (valid_out) begin
                got = 1'b1;
                break;
            end
            if (rnd_trig && ($urandom % 4 == 0)) begin
                trig = 1'b1;
                ovr_exp++;
            end
        end
    endtask

    task automatic start_set(input logic [DW-1:0] a, b, c, ang, input bit ready);
        adc_vals = '{a, b, c, ang};
        e_a = sat(a, offA); e_b = sat(b, offB); e_c = sat(c, offC); e_ang = ang;
        e_t = DW'($urandom); e_p = DW'($urandom);
        ready_in = ready;
        enable = 1'b1; trig = 1'b1; currT_in = e_t; periodTop_in = e_p;
        step();
        trig = 1'b0;
        currT_in = DW'($urandom); periodTop_in = DW'($urandom);
    endtask

    task automatic do_set(input logic [DW-1:0] a, b, c, ang, input int hold, input bit rnd_trig);
        int k, req0, lsum;
        bit got;
        lsum = 0;
        for (int i = 0; i < 4; i++) lsum += 1 + adc_lat[i];
        req0 = req_cnt;
        start_set(a, b, c, ang, hold == 0);
        enable = rnd_trig ? 1'($urandom % 2) : 1'b1;
        check("busy_after_trig", busy, 1);
        wait_valid(rnd_trig, k, got);
        check("valid_seen", got, 1);
        check("latency", k, lsum);
        check("set_out", {angle_out, currA_out, currB_out, currC_out, currT_out, periodTop_out},
              {e_ang, e_a, e_b, e_c, e_t, e_p});
        check("req_count", req_cnt - req0, 4);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_stable", {valid_out, angle_out, currA_out, currB_out, currC_out, currT_out, periodTop_out},
                  {1'b1, e_ang, e_a, e_b, e_c, e_t, e_p});
        end
        ready_in = 1'b1;
        trig = rnd_trig ? 1'($urandom % 2) : 1'b0;
        if (trig) ovr_exp++;
        step();
        ready_in = 1'b0;
        trig = 1'b0;
        enable = 1'b1;
        check("xfer_done", {valid_out, busy}, 2'b00);
        check("ovr", ovr_cnt, ovr_model());
    endtask

    initial begin
        int k, req0;
        bit got, saw_valid;
        adc_lat = '{1, 1, 1, 1};
        adc_vals = '{16'h0, 16'h0, 16'h0, 16'h0};
        #1;
        check("reset_outs", {adc_req, adc_ch, valid_out, busy, adc_err, ovr_cnt, angle_out, currA_out,
              currB_out, currC_out, currT_out, periodTop_out}, 0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        step();

        // nominal
        offA = 16'h0010; offB = 16'hFFF0; offC = 16'h0000;
        do_set(16'h0100, 16'hFF00, 16'h0000, 16'h4000, 0, 1'b0);
        check("nom_consts", {currA_out, currB_out, currC_out, angle_out},
              {16'h00F0, 16'hFF10, 16'h0000, 16'h4000});

        // saturation
        offA = 16'hFF00; offB = 16'h0100;
        do_set(16'h7FF0, 16'h8010, 16'h1234, 16'h0ABC, 2, 1'b0);
        check("sat_consts", {currA_out, currB_out}, {16'h7FFF, 16'h8000});

        // backpressure + overrun while presenting
        start_set(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
        wait_valid(1'b0, k, got);
        check("ovr_valid_seen", got, 1);
        req0 = req_cnt;
        for (int i = 0; i < 3; i++) begin
            trig = 1'b1; step(); trig = 1'b0; step();
        end
        ovr_exp += 3;
        check("ovr_three", ovr_cnt, ovr_model());
        trig = 1'b1;
        repeat (300) step();
        trig = 1'b0;
        ovr_exp += 300;
        repeat (2) step();
        check("ovr_saturate", ovr_cnt, ovr_model());
        check("ovr_no_req", req_cnt - req0, 0);
        check("bp_stable", {valid_out, angle_out, currA_out, currB_out, currC_out, currT_out, periodTop_out},
              {1'b1, e_ang, e_a, e_b, e_c, e_t, e_p});
        ready_in = 1'b1; step(); ready_in = 1'b0;
        check("bp_release", {valid_out, busy}, 2'b00);

        // timeout on channel 2, clr_err held high to show set wins
        mute_ch = 2;
        clr_err = 1'b1;
        enable = 1'b1; trig = 1'b1; step(); trig = 1'b0;
        k = 0; saw_valid = 1'b0;
        while (k < 400 && !adc_err) begin
            step();
            k++;
            if (valid_out) saw_valid = 1'b1;
        end
        clr_err = 1'b0;
        check("to_latency", k, (1 + adc_lat[0]) + (1 + adc_lat[1]) + 1 + TO);
        check("to_state", {adc_err, busy, valid_out, saw_valid}, 4'b1000);
        repeat (3) step();
        check("err_sticky", adc_err, 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("err_cleared", adc_err, 0);
        mute_ch = -1;
        offA = 16'h0005; offB = 16'h0000; offC = 16'hFFFB;
        do_set(16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 1, 1'b0);

        // randomized sets
        for (int n = 0; n < 12; n++) begin
            offA = DW'($urandom); offB = DW'($urandom); offC = DW'($urandom);
            for (int i = 0; i < 4; i++) adc_lat[i] = 1 + ($urandom % 3);
            do_set(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), $urandom % 5, 1'b1);
        end

        // reset during WAIT on channel 1
        adc_lat = '{1, 1, 1, 1};
        enable = 1'b1; trig = 1'b1; step(); trig = 1'b0;
        repeat (3) step();
        check("pre_reset_ch", {busy, adc_ch}, 3'b101);
        #2 rstb = 1'b0;
        #1;
        ovr_exp = 0;
        check("async_reset", {adc_req, adc_ch, valid_out, busy, adc_err, ovr_cnt, angle_out, currA_out,
              currB_out, currC_out, currT_out, periodTop_out}, 0);
        @(negedge clk);
        rstb = 1'b1;
        step();
        req0 = req_cnt;
        enable = 1'b0; trig = 1'b1; step(); trig = 1'b0;
        repeat (5) step();
        check("dis_no_req", req_cnt - req0, 0);
        check("dis_idle", {busy, valid_out, ovr_cnt}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
